pc_fetch_seq: RTL and testbench
===============================

// Module: pc_fetch_seq
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for the multi-cycle/handshaked core.
//  Holds PC[31:2], issues word fetches to instruction memory over a valid/ready request channel,
//  captures the response, and presents {inst, inst_pc} to the datapath with a valid/ready handshake.
//  Consumes the next-PC word address computed by the next-PC logic when the datapath accepts an instruction.
// PARAMETERS
//  RESET_PC     30'h0000_0C00  word address loaded on reset (byte address 0x0000_3000)
//  MEM_TIMEOUT  255            max cycles in WAIT before fetch_err; 0 disables the timeout
//  CNT_W        8              timeout counter width; must satisfy MEM_TIMEOUT < 2**CNT_W
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts request
//  imem_addr      out  30  fetch word address, PC[31:2]
//  imem_rsp_valid in   1   read data valid, single-cycle pulse
//  imem_rsp_data  in   32  read data
//  inst_valid     out  1   instruction valid to datapath
//  inst_ready     in   1   datapath accepts instruction
//  inst           out  32  fetched instruction
//  inst_pc        out  30  word address of inst
//  npc            in   30  next PC word address; sampled only on inst_valid && inst_ready
//  pc             out  30  current PC register
//  fetch_err      out  1   sticky timeout flag
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, cnt=0, fetch_err=0;
//   imem_req_valid=0, inst_valid=0. imem_addr always equals pc.
//  FSM (registered state; outputs decoded from state):
//   IDLE : all valids 0. Go to REQ next cycle, unconditionally.
//   REQ  : imem_req_valid=1; imem_addr=pc held stable until accepted.
//          On imem_req_valid && imem_req_ready -> WAIT, cnt<=0.
//   WAIT : imem_req_valid=0.
//          imem_rsp_valid=1 -> inst<=imem_rsp_data, inst_pc<=pc, go to HOLD.
//          Otherwise cnt<=cnt+1. If MEM_TIMEOUT!=0 and cnt==MEM_TIMEOUT-1 -> ERR.
//   HOLD : inst_valid=1; inst and inst_pc held stable.
//          On inst_ready -> pc<=npc, go to REQ. New imem_addr is visible the next cycle.
//   ERR  : fetch_err=1; all valids 0; pc frozen. Exit only by reset.
//  Latency: request accepted at cycle N, response at N+k (k>=1) -> inst_valid at N+k+1.
//   Handshake at cycle M -> next imem_req_valid at M+1.
//  Edge cases:
//   - imem_rsp_valid outside WAIT is ignored, including stale responses after reset.
//   - Response in the same cycle the timeout would fire: the response wins; go to HOLD, no error.
//   - Response in the same cycle as request acceptance is not legal (k>=1).
//     Any such response is ignored; the block stays in WAIT.
//   - npc is taken verbatim (30 bits, no alignment check). Wrap 30'h3FFF_FFFF+1 is npc's concern.
//   - At most one outstanding request; no request is issued while in WAIT or HOLD.
//   - Reset asserted in any state returns all outputs to reset values immediately.
// TESTING
//  1 Reset: hold rst_n=0 -> pc=30'h0C00, imem_req_valid=0, inst_valid=0, fetch_err=0.
//    Release -> cycle+1 imem_req_valid=1, imem_addr=30'h0C00.
//  2 Sequential: req_ready=1; rsp 2 cycles later, data 32'h8C01_0000
//    -> inst_valid=1, inst=32'h8C01_0000, inst_pc=30'h0C00.
//    Then inst_ready=1, npc=30'h0C01 -> next imem_addr=30'h0C01.
//  3 Backpressure: req_ready=0 for 3 cycles -> addr and valid stable, then accept.
//    inst_ready=0 for 5 cycles -> inst and inst_pc unchanged, pc unchanged.
//  4 Jump: handshake with npc=30'h0040_0000 -> next request addr=30'h0040_0000, pc=30'h0040_0000.
//  5 Timeout: MEM_TIMEOUT=4, no rsp -> fetch_err=1 after the 4th WAIT cycle, valids 0.
//    Later rsp is ignored. Boundary: rsp exactly on the 4th cycle -> HOLD, fetch_err=0.
//  6 Reset mid-WAIT: assert rst_n=0 while in WAIT -> outputs reset immediately.
//    Stale rsp one cycle after release (IDLE) is ignored; fetch restarts at 30'h0C00.

Source files
------------

// File: rtl/pc_fetch_seq.sv
// -----------------------------------------------------------------------------
// pc_fetch_seq
//   Program-counter register and instruction-fetch sequencer for the
//   multi-cycle, handshaked core. It holds PC[31:2] and issues one word fetch
//   at a time to instruction memory over a valid/ready request channel. It
//   captures the single-cycle read response and presents {inst, inst_pc} to
//   the datapath with a valid/ready handshake. When the datapath accepts an
//   instruction, the PC is loaded with the next-PC word address (npc).
//
// Parameters
//   RESET_PC     word address loaded on reset
//   MEM_TIMEOUT  max cycles spent waiting for a response before fetch_err;
//                0 disables the timeout
//   CNT_W        timeout counter width (MEM_TIMEOUT < 2**CNT_W)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_req_valid   fetch request valid                      (out)
//   imem_req_ready   memory accepts request                   (in)
//   imem_addr[29:0]  fetch word address, always equal to pc   (out)
//   imem_rsp_valid   read data valid, single-cycle pulse      (in)
//   imem_rsp_data    read data                                (in)
//   inst_valid       instruction valid to datapath            (out)
//   inst_ready       datapath accepts instruction             (in)
//   inst[31:0]       fetched instruction                      (out)
//   inst_pc[29:0]    word address of inst                     (out)
//   npc[29:0]        next PC, sampled only on inst handshake  (in)
//   pc[29:0]         current PC register                      (out)
//   fetch_err        sticky memory-timeout flag               (out)
// -----------------------------------------------------------------------------
module pc_fetch_seq #(
  parameter logic [29:0] RESET_PC    = 30'h0000_0C00,
  parameter int          MEM_TIMEOUT = 255,
  parameter int          CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [29:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  input  logic [29:0] npc,
  output logic [29:0] pc,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Value of cnt on the last permitted WAIT cycle. When the timeout is
  // disabled the cast wraps to all ones, but TIMEOUT_EN masks it off.
  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

  // The request address is the PC itself. The PC only changes on the
  // instruction handshake, so the address is stable while a request is
  // waiting for acceptance.
  assign imem_addr = pc;

  // The output flags are registered together with the state, so each one
  // is a clean flop that always equals its state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      inst           <= '0;
      inst_pc        <= '0;
      cnt            <= '0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      fetch_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
        end

        // A response arriving in the same cycle the request is accepted is
        // not legal. It is dropped here because responses are only looked
        // at in WAIT.
        S_REQ: begin
          if (imem_req_ready) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
            cnt            <= '0;
          end
        end

        // When a response and a timeout land in the same cycle, the
        // response wins.
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            state      <= S_HOLD;
            inst_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (timeout_hit) begin
              state     <= S_ERR;
              fetch_err <= 1'b1;
            end
          end
        end

        // npc is taken verbatim, with no alignment or wrap handling.
        S_HOLD: begin
          if (inst_ready) begin
            pc             <= npc;
            state          <= S_REQ;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
          end
        end

        // Terminal state: only reset leaves it. pc is frozen.
        S_ERR: begin
          state <= S_ERR;
        end

        default: begin
          state          <= S_IDLE;
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
module tb_pc_fetch_seq;

  localparam logic [29:0] RESET_PC = 30'h0000_0C00;
  localparam int          TMO      = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [29:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [29:0] inst_pc;
  logic [29:0] npc;
  logic [29:0] pc;
  logic        fetch_err;

  pc_fetch_seq #(
    .RESET_PC    (RESET_PC),
    .MEM_TIMEOUT (TMO),
    .CNT_W       (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .npc            (npc),
    .pc             (pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction stream the core must present, in order.
  typedef struct packed {
    logic [31:0] data;
    logic [29:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  logic [29:0] model_pc;
  bit          exp_err, err_arm, tmo_req, tmo_mode, stale_en, mon_en;
  int          pend, n_fetch, n_done, force_k, req_stall, inst_stall;
  bit          prev_rv, prev_rr, prev_iv, prev_ir;
  logic [29:0] prev_npc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the model.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("pc_reg", 64'(pc), 64'(model_pc));
      chk("fetch_err", 64'(fetch_err), 64'(exp_err));
      chk("req_and_inst_both_valid", 64'(imem_req_valid & inst_valid), 64'd0);
      if (imem_req_valid) chk("imem_addr", 64'(imem_addr), 64'(model_pc));
      if (exp_err) chk("err_valids", 64'({imem_req_valid, inst_valid}), 64'd0);
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inst_valid", 64'(inst_valid), 64'd0);
        end else begin
          chk("inst", 64'(inst), 64'(exp_q[0].data));
          chk("inst_pc", 64'(inst_pc), 64'(exp_q[0].pc));
          if (inst_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [29:0] pick_npc();
    logic [29:0] r;
    if (n_done == 0)      r = 30'h0000_0C01;
    else if (n_done == 1) r = 30'h0040_0000;
    else begin
      case ($urandom_range(0, 3))
        0, 1:    r = model_pc + 30'd1;
        2:       r = 30'($urandom);
        default: r = 30'h3FFF_FFFF;
      endcase
    end
    return r;
  endfunction

  // One clock of memory + consumer behaviour, driven just after the edge.
  task automatic step();
    bit hs_req, hs_inst;
    int k;
    @(posedge clk);
    #1;
    hs_req  = prev_rv && prev_rr;
    hs_inst = prev_iv && prev_ir;
    if (hs_inst) begin
      model_pc = prev_npc;
      n_done++;
    end
    if (err_arm) begin
      exp_err = 1'b1;
      err_arm = 1'b0;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (hs_req) begin
      chk("one_outstanding", 64'(pend), 64'd0);
      n_fetch++;
      if (tmo_req)           k = TMO;
      else if (force_k != 0) k = force_k;
      else if (n_fetch == 1) k = 2;
      else if (n_fetch == 2) k = TMO;
      else                   k = $urandom_range(1, TMO);
      tmo_mode = tmo_req;
      pend     = k;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        if (tmo_mode) err_arm = 1'b1;
        else begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = (n_fetch == 1) ? 32'h8C01_0000 : $urandom;
          exp_q.push_back('{data: imem_rsp_data, pc: model_pc});
        end
      end
    end else if (stale_en && (!tmo_mode || exp_err) &&
                 (exp_err || $urandom_range(0, 3) == 0)) begin
      imem_rsp_valid = 1'b1;
    end

    if (n_fetch == 0 && imem_req_valid && req_stall < 3) begin
      imem_req_ready = 1'b0;
      req_stall++;
    end else begin
      imem_req_ready = ($urandom_range(0, 2) != 0);
    end
    if (n_done == 0 && inst_valid && inst_stall < 5) begin
      inst_ready = 1'b0;
      inst_stall++;
    end else begin
      inst_ready = ($urandom_range(0, 1) != 0);
    end
    npc = pick_npc();

    prev_rv  = imem_req_valid;
    prev_rr  = imem_req_ready;
    prev_iv  = inst_valid;
    prev_ir  = inst_ready;
    prev_npc = npc;
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_pc = RESET_PC;
    pend     = 0;
    exp_err  = 1'b0;
    err_arm  = 1'b0;
    tmo_req  = 1'b0;
    tmo_mode = 1'b0;
    prev_rv  = 1'b0;
    prev_rr  = 1'b0;
    prev_iv  = 1'b0;
    prev_ir  = 1'b0;
    prev_npc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, 64'(pc), 64'(RESET_PC));
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_fetch_err"}, 64'(fetch_err), 64'd0);
    chk({tag, "_inst"}, 64'(inst), 64'd0);
    chk({tag, "_inst_pc"}, 64'(inst_pc), 64'd0);
  endtask

  // Assert reset asynchronously mid-cycle, then release with a stale response
  // presented while the DUT is in IDLE.
  task automatic reset_and_release(input string tag);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_vals(tag);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n          = 1'b1;
    mon_en         = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    chk({tag, "_restart_req_valid"}, 64'(imem_req_valid), 64'd1);
    chk({tag, "_restart_addr"}, 64'(imem_addr), 64'(RESET_PC));
    chk({tag, "_stale_ignored"}, 64'(inst_valid), 64'd0);
  endtask

  task automatic run_until(input int target, input int budget);
    int c;
    c = 0;
    while (n_done < target && c < budget) begin
      step();
      c++;
    end
    chk("progress", 64'(n_done >= target), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    mon_en = 1'b0;
    stale_en = 1'b0;
    npc = '0;
    imem_rsp_data = '0;
    n_fetch = 0;
    n_done = 0;
    force_k = 0;
    req_stall = 0;
    inst_stall = 0;
    reset_model();

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("idle_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", 64'(imem_addr), 64'(RESET_PC));

    // Sequential fetch, backpressure, jump, then randomized traffic.
    stale_en = 1'b1;
    run_until(40, 4000);

    // Timeout: the next accepted request never gets a response.
    tmo_req = 1'b1;
    for (int i = 0; i < 300 && !exp_err; i++) step();
    chk("timeout_reached", 64'(exp_err), 64'd1);
    repeat (6) step();

    // Leave ERR via reset, then reset again while waiting for a response.
    reset_and_release("err_reset");
    force_k = TMO;
    for (int i = 0; i < 200 && pend == 0; i++) step();
    chk("reached_wait", 64'(pend > 0), 64'd1);
    reset_and_release("wait_reset");
    force_k = 0;
    run_until(n_done + 10, 2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
